rotate_addr_gen: RTL and testbench
==================================

ROTATE_ADDR_GEN -- requirements
Module: rotate_addr_gen

Interface
REQ-001 SHALL have ports: I_PCLK  in  1  sole clock, rising edge.
REQ-002 SHALL have: I_PRESET_N  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have: I_START  in  1  start pulse from register file (its O_START).
REQ-004 SHALL have: I_ABORT  in  1  cancel job.
REQ-005 SHALL have: I_WIDTH  in  10  source width, pixels; I_HEIGHT  in  10  source height, pixels.
REQ-006 SHALL have: I_DIR  in  2  rotation: 0=0deg, 1=90cw, 2=180, 3=270cw.
REQ-007 SHALL have: I_SRC_BASE  in  32; I_DST_BASE  in  32  base addresses, pixel units.
REQ-008 SHALL have: O_SRC_ADDR  out  32; O_DST_ADDR  out  32  address pair.
REQ-009 SHALL have: O_VALID  out  1; I_READY  in  1  consumer handshake.
REQ-010 SHALL have: O_BUSY  out  1; O_DONE  out  1  one-cycle completion pulse (to interrupt logic).

Function
REQ-011 SHALL implement states IDLE, RUN, DONE.
REQ-012 IDLE: I_START=1 at edge N latches I_WIDTH, I_HEIGHT, I_DIR, both bases; x=y=0; -> RUN.
REQ-013 RUN: O_VALID=1, O_BUSY=1 from edge N+1; first pair is pixel (0,0).
REQ-014 Scan raster order, x fastest; O_SRC_ADDR = SRC_BASE + y*W + x.
REQ-015 O_DST_ADDR = DST_BASE + idx; idx: dir0 y*W+x; dir1 x*H+(H-1-y); dir2 (H-1-y)*W+(W-1-x); dir3 (W-1-x)*H+y.
REQ-016 Index math SHALL be 20-bit unsigned; address add SHALL be 32-bit modulo 2^32 (wrap, no flag).
REQ-017 Handshake: advance only at edge with O_VALID&I_READY; outputs SHALL stay stable while O_VALID&!I_READY.
REQ-018 Throughput: one pair per cycle when I_READY held high.
REQ-019 x wraps W-1 -> 0 with y+1; handshake on (W-1,H-1) -> DONE, O_VALID=0 next cycle.
REQ-020 DONE: O_DONE=1, O_BUSY=0 for exactly one cycle, then IDLE.
REQ-021 W=0 or H=0 at start: -> DONE directly; O_VALID never asserts.
REQ-022 I_START in RUN or DONE SHALL be ignored; config inputs changing mid-job SHALL have no effect.
REQ-023 I_ABORT=1 in RUN/DONE: -> IDLE next edge, O_VALID=0, no O_DONE; abort wins over simultaneous handshake.
REQ-024 I_ABORT and I_START together in IDLE: abort wins, stay IDLE.

Reset
REQ-025 I_PRESET_N=0 SHALL immediately force IDLE, x=y=0, O_VALID=0, O_BUSY=0, O_DONE=0, O_SRC_ADDR=0, O_DST_ADDR=0.
REQ-026 Reset mid-job SHALL discard job; no O_DONE after release.
REQ-027 First I_START accepted is at the first rising edge with I_PRESET_N=1.

Configuration
REQ-028 Macro ROTATE_ADDR_GEN_PERF_EN defined: add O_CYCLES out 32; cleared at accepted start; +1 each RUN cycle, stalls included; held until next start; reset 0.
REQ-029 Macro undefined: no O_CYCLES port, no counter logic; all other behaviour identical.

Structure
REQ-030 Shared package rotate_pkg SHALL hold direction encodings (DIR_0/90/180/270), dimension width 10, address width 32, state encodings.
REQ-031 Destination mapping (REQ-015) SHALL live in one combinational sub-module rotate_map; counters, FSM, handshake in rotate_addr_gen.

Verification
REQ-032 W=4,H=2,dir1,SRC=0x100,DST=0x200, READY=1 -> 8 pairs, dst sequence 0x201,0x203,0x205,0x207,0x200,0x202,0x204,0x206; O_DONE 1 cycle after 8th handshake.
REQ-033 W=3,H=3,dir2, READY toggled 1/0 -> 9 pairs, first dst=DST+8, last dst=DST+0; addresses stable during every stall.
REQ-034 W=0,H=5 start -> O_VALID never high, O_DONE pulse at edge N+1.
REQ-035 Abort after 3 handshakes with READY=1 same cycle -> O_VALID low next cycle, no O_DONE; new start then runs full job from (0,0).
REQ-036 PRESET_N low during RUN -> outputs zero immediately; START during RUN ignored; SRC_BASE=0xFFFFFFFF,W=2,H=1 -> src 0xFFFFFFFF, 0x00000000.
REQ-037 With ROTATE_ADDR_GEN_PERF_EN, W=2,H=2 with 3 stall cycles -> O_CYCLES=7.

Source files
------------

// File: rtl/rotate_pkg.sv
// Shared definitions for the rotation address generator: dimension, index and
// address widths, direction codes and the job FSM state codes.
package rotate_pkg;

    localparam int DIM_W  = 10;
    localparam int IDX_W  = 2 * DIM_W;
    localparam int ADDR_W = 32;

    localparam logic [DIM_W-1:0] DIM_ZERO = '0;
    localparam logic [DIM_W-1:0] DIM_ONE  = DIM_W'(1);

    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_90  = 2'd1,
        DIR_180 = 2'd2,
        DIR_270 = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rotate_addr_gen_if.sv
// Job configuration, address stream handshake and status of the rotation
// address generator. O_CYCLES exists only when ROTATE_ADDR_GEN_PERF_EN is defined.
interface rotate_addr_gen_if;
    import rotate_pkg::*;

    logic                  I_START;
    logic                  I_ABORT;
    logic [DIM_W-1:0]      I_WIDTH;
    logic [DIM_W-1:0]      I_HEIGHT;
    logic [1:0]            I_DIR;
    logic [ADDR_W-1:0]     I_SRC_BASE;
    logic [ADDR_W-1:0]     I_DST_BASE;
    logic [ADDR_W-1:0]     O_SRC_ADDR;
    logic [ADDR_W-1:0]     O_DST_ADDR;
    logic                  O_VALID;
    logic                  I_READY;
    logic                  O_BUSY;
    logic                  O_DONE;
`ifdef ROTATE_ADDR_GEN_PERF_EN
    logic [31:0]           O_CYCLES;
`endif

    // Register file / consumer side.
    modport master (
        output I_START, I_ABORT, I_WIDTH, I_HEIGHT, I_DIR, I_SRC_BASE, I_DST_BASE, I_READY,
        input  O_SRC_ADDR, O_DST_ADDR, O_VALID, O_BUSY, O_DONE
`ifdef ROTATE_ADDR_GEN_PERF_EN
        , input O_CYCLES
`endif
    );

    // Address generator side.
    modport slave (
        input  I_START, I_ABORT, I_WIDTH, I_HEIGHT, I_DIR, I_SRC_BASE, I_DST_BASE, I_READY,
        output O_SRC_ADDR, O_DST_ADDR, O_VALID, O_BUSY, O_DONE
`ifdef ROTATE_ADDR_GEN_PERF_EN
        , output O_CYCLES
`endif
    );

endinterface

// File: rtl/rotate_map.sv
// Combinational mapping of a source pixel (x, y) of a WxH image to its linear
// index in the rotated destination image. All arithmetic is 20-bit unsigned.
module rotate_map
    import rotate_pkg::*;
(
    input  logic [DIM_W-1:0] x,
    input  logic [DIM_W-1:0] y,
    input  logic [DIM_W-1:0] w,
    input  logic [DIM_W-1:0] h,
    input  dir_t             dir,
    output logic [IDX_W-1:0] idx
);

    logic [DIM_W-1:0] row_flip;
    logic [DIM_W-1:0] col_flip;

    assign row_flip = h - DIM_ONE - y;
    assign col_flip = w - DIM_ONE - x;

    // Select the destination index for the requested rotation.
    always_comb begin
        idx = '0;
        case (dir)
            DIR_0:   idx = IDX_W'(y) * IDX_W'(w) + IDX_W'(x);
            DIR_90:  idx = IDX_W'(x) * IDX_W'(h) + IDX_W'(row_flip);
            DIR_180: idx = IDX_W'(row_flip) * IDX_W'(w) + IDX_W'(col_flip);
            DIR_270: idx = IDX_W'(col_flip) * IDX_W'(h) + IDX_W'(y);
            default: idx = '0;
        endcase
    end

endmodule

// File: rtl/rotate_addr_gen.sv
// Rotation address generator: walks a WxH source image in raster order and
// emits (source, destination) address pairs over a valid/ready handshake.
// Optional cycle counter enabled by defining ROTATE_ADDR_GEN_PERF_EN.
module rotate_addr_gen
    import rotate_pkg::*;
(
    input  logic                I_PCLK,
    input  logic                I_PRESET_N,
    rotate_addr_gen_if.slave    bus
);

    state_t              state_reg;
    logic [DIM_W-1:0]    x_reg;
    logic [DIM_W-1:0]    y_reg;
    logic [DIM_W-1:0]    w_reg;
    logic [DIM_W-1:0]    h_reg;
    dir_t                dir_reg;
    logic [ADDR_W-1:0]   src_base_reg;
    logic [ADDR_W-1:0]   dst_base_reg;
    logic [ADDR_W-1:0]   src_addr_reg;
    logic [ADDR_W-1:0]   dst_addr_reg;
    logic                valid_reg;
    logic                busy_reg;
    logic                done_reg;

    logic                is_idle;
    logic                start_ok;
    logic                advance;
    logic                last_col;
    logic                last_row;
    logic [DIM_W-1:0]    x_next;
    logic [DIM_W-1:0]    y_next;
    logic [DIM_W-1:0]    map_x;
    logic [DIM_W-1:0]    map_y;
    logic [DIM_W-1:0]    cfg_w;
    logic [DIM_W-1:0]    cfg_h;
    dir_t                cfg_dir;
    logic [ADDR_W-1:0]   cfg_src;
    logic [ADDR_W-1:0]   cfg_dst;
    logic [IDX_W-1:0]    src_idx;
    logic [IDX_W-1:0]    dst_idx;
    logic [ADDR_W-1:0]   src_addr_next;
    logic [ADDR_W-1:0]   dst_addr_next;

    assign is_idle  = (state_reg == IDLE);
    assign start_ok = is_idle && bus.I_START && !bus.I_ABORT;
    assign advance  = (state_reg == RUN) && valid_reg && bus.I_READY;
    assign last_col = (x_reg == (w_reg - DIM_ONE));
    assign last_row = (y_reg == (h_reg - DIM_ONE));
    assign x_next   = last_col ? DIM_ZERO : (x_reg + DIM_ONE);
    assign y_next   = last_col ? (y_reg + DIM_ONE) : y_reg;

    // The pair loaded at a start uses the live inputs at pixel (0,0); later
    // pairs use the latched job and the next scan position.
    assign cfg_w   = is_idle ? bus.I_WIDTH      : w_reg;
    assign cfg_h   = is_idle ? bus.I_HEIGHT     : h_reg;
    assign cfg_dir = is_idle ? dir_t'(bus.I_DIR) : dir_reg;
    assign cfg_src = is_idle ? bus.I_SRC_BASE   : src_base_reg;
    assign cfg_dst = is_idle ? bus.I_DST_BASE   : dst_base_reg;
    assign map_x   = is_idle ? DIM_ZERO : x_next;
    assign map_y   = is_idle ? DIM_ZERO : y_next;

    assign src_idx = IDX_W'(map_y) * IDX_W'(cfg_w) + IDX_W'(map_x);

    rotate_map u_map (
        .x   (map_x),
        .y   (map_y),
        .w   (cfg_w),
        .h   (cfg_h),
        .dir (cfg_dir),
        .idx (dst_idx)
    );

    // Address adds wrap modulo 2^32.
    assign src_addr_next = cfg_src + ADDR_W'(src_idx);
    assign dst_addr_next = cfg_dst + ADDR_W'(dst_idx);

    // Job FSM with registered handshake, status and address outputs.
    always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
        if (!I_PRESET_N) begin
            state_reg    <= IDLE;
            x_reg        <= '0;
            y_reg        <= '0;
            w_reg        <= '0;
            h_reg        <= '0;
            dir_reg      <= DIR_0;
            src_base_reg <= '0;
            dst_base_reg <= '0;
            src_addr_reg <= '0;
            dst_addr_reg <= '0;
            valid_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start_ok) begin
                        w_reg        <= bus.I_WIDTH;
                        h_reg        <= bus.I_HEIGHT;
                        dir_reg      <= dir_t'(bus.I_DIR);
                        src_base_reg <= bus.I_SRC_BASE;
                        dst_base_reg <= bus.I_DST_BASE;
                        x_reg        <= '0;
                        y_reg        <= '0;
                        if ((bus.I_WIDTH == DIM_ZERO) || (bus.I_HEIGHT == DIM_ZERO)) begin
                            // Empty image: no pairs, straight to completion.
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg    <= RUN;
                            valid_reg    <= 1'b1;
                            busy_reg     <= 1'b1;
                            src_addr_reg <= src_addr_next;
                            dst_addr_reg <= dst_addr_next;
                        end
                    end
                end
                RUN: begin
                    if (bus.I_ABORT) begin
                        state_reg <= IDLE;
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                    end else if (advance) begin
                        if (last_col && last_row) begin
                            state_reg <= DONE;
                            valid_reg <= 1'b0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            x_reg        <= x_next;
                            y_reg        <= y_next;
                            src_addr_reg <= src_addr_next;
                            dst_addr_reg <= dst_addr_next;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.O_SRC_ADDR = src_addr_reg;
    assign bus.O_DST_ADDR = dst_addr_reg;
    assign bus.O_VALID    = valid_reg;
    assign bus.O_BUSY     = busy_reg;
    assign bus.O_DONE     = done_reg;

`ifdef ROTATE_ADDR_GEN_PERF_EN
    logic [31:0] cycles_reg;

    // Count every RUN cycle, stalls included; restart at each accepted start.
    always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
        if (!I_PRESET_N) begin
            cycles_reg <= '0;
        end else if (start_ok) begin
            cycles_reg <= '0;
        end else if (state_reg == RUN) begin
            cycles_reg <= cycles_reg + 32'd1;
        end
    end

    assign bus.O_CYCLES = cycles_reg;
`endif

endmodule

// File: tb/tb_rotate_addr_gen.sv
// Directed bench for rotate_addr_gen: reset, rotations, stalls, empty jobs,
// abort, mid-job reset, address wrap and (when enabled) the cycle counter.
`timescale 1ns/1ps
module tb_rotate_addr_gen;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    rotate_addr_gen_if bus ();

    rotate_addr_gen dut (
        .I_PCLK     (clk),
        .I_PRESET_N (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [9:0] w, input logic [9:0] h, input logic [1:0] dir,
                             input logic [31:0] src, input logic [31:0] dst);
        bus.I_WIDTH    = w;
        bus.I_HEIGHT   = h;
        bus.I_DIR      = dir;
        bus.I_SRC_BASE = src;
        bus.I_DST_BASE = dst;
        bus.I_START    = 1'b1;
        tick();
        bus.I_START    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.O_VALID, bus.O_BUSY, bus.O_DONE} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {bus.O_VALID, bus.O_BUSY, bus.O_DONE}); end
        n_cmp++; if ({bus.O_SRC_ADDR, bus.O_DST_ADDR} !== 64'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", {bus.O_SRC_ADDR, bus.O_DST_ADDR}); end
        // Start held through reset must be ignored until release.
        bus.I_WIDTH = 10'd1; bus.I_HEIGHT = 10'd1; bus.I_DIR = 2'd0;
        bus.I_SRC_BASE = 32'h55; bus.I_DST_BASE = 32'h66; bus.I_START = 1'b1;
        tick(); tick();
        n_cmp++; if (bus.O_VALID !== 1'b0) begin n_bad++; $display("FAIL start_in_reset: valid got %b want 0", bus.O_VALID); end
        rst_n = 1'b1;
        tick();
        bus.I_START = 1'b0;
        n_cmp++; if (bus.O_VALID !== 1'b1 || bus.O_BUSY !== 1'b1) begin n_bad++; $display("FAIL first_start: valid/busy got %b%b want 11", bus.O_VALID, bus.O_BUSY); end
        n_cmp++; if (bus.O_SRC_ADDR !== 32'h55 || bus.O_DST_ADDR !== 32'h66) begin n_bad++; $display("FAIL first_pair: got %h/%h want 55/66", bus.O_SRC_ADDR, bus.O_DST_ADDR); end
        bus.I_READY = 1'b1;
        tick();
        n_cmp++; if (bus.O_DONE !== 1'b1 || bus.O_VALID !== 1'b0) begin n_bad++; $display("FAIL single_done: done/valid got %b%b want 10", bus.O_DONE, bus.O_VALID); end
        tick();
        n_cmp++; if (bus.O_DONE !== 1'b0) begin n_bad++; $display("FAIL done_width: done got %b want 0", bus.O_DONE); end
    endtask

    task automatic test_dir90();
        logic [31:0] exp_dst [8];
        exp_dst = '{32'h201, 32'h203, 32'h205, 32'h207, 32'h200, 32'h202, 32'h204, 32'h206};
        bus.I_READY = 1'b1;
        start_job(10'd4, 10'd2, 2'd1, 32'h100, 32'h200);
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (bus.O_VALID !== 1'b1 || bus.O_BUSY !== 1'b1) begin n_bad++; $display("FAIL dir90_valid[%0d]: got %b%b want 11", k, bus.O_VALID, bus.O_BUSY); end
            n_cmp++; if (bus.O_SRC_ADDR !== 32'h100 + 32'(k)) begin n_bad++; $display("FAIL dir90_src[%0d]: got %h want %h", k, bus.O_SRC_ADDR, 32'h100 + 32'(k)); end
            n_cmp++; if (bus.O_DST_ADDR !== exp_dst[k]) begin n_bad++; $display("FAIL dir90_dst[%0d]: got %h want %h", k, bus.O_DST_ADDR, exp_dst[k]); end
            tick();
        end
        n_cmp++; if ({bus.O_VALID, bus.O_BUSY, bus.O_DONE} !== 3'b001) begin n_bad++; $display("FAIL dir90_done: v/b/d got %b want 001", {bus.O_VALID, bus.O_BUSY, bus.O_DONE}); end
        tick();
        n_cmp++; if (bus.O_DONE !== 1'b0) begin n_bad++; $display("FAIL dir90_done_pulse: got %b want 0", bus.O_DONE); end
    endtask

    task automatic test_dir270();
        logic [31:0] exp_dst [6];
        exp_dst = '{32'd4, 32'd2, 32'd0, 32'd5, 32'd3, 32'd1};
        bus.I_READY = 1'b1;
        start_job(10'd3, 10'd2, 2'd3, 32'h0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            n_cmp++; if (bus.O_DST_ADDR !== exp_dst[k] || bus.O_VALID !== 1'b1) begin n_bad++; $display("FAIL dir270_dst[%0d]: got %h valid %b want %h", k, bus.O_DST_ADDR, bus.O_VALID, exp_dst[k]); end
            tick();
        end
        n_cmp++; if (bus.O_DONE !== 1'b1) begin n_bad++; $display("FAIL dir270_done: got %b want 1", bus.O_DONE); end
        tick();
    endtask

    task automatic test_stall_dir180();
        logic [31:0] held_src;
        logic [31:0] held_dst;
        bus.I_READY = 1'b0;
        start_job(10'd3, 10'd3, 2'd2, 32'h1000, 32'h2000);
        // Changing configuration mid-job must not disturb the job.
        bus.I_WIDTH = 10'd9; bus.I_HEIGHT = 10'd7; bus.I_DIR = 2'd0;
        bus.I_SRC_BASE = 32'hDEAD0000; bus.I_DST_BASE = 32'hBEEF0000;
        for (int k = 0; k < 9; k++) begin
            n_cmp++; if (bus.O_SRC_ADDR !== 32'h1000 + 32'(k) || bus.O_DST_ADDR !== 32'h2008 - 32'(k)) begin n_bad++; $display("FAIL dir180_pair[%0d]: got %h/%h want %h/%h", k, bus.O_SRC_ADDR, bus.O_DST_ADDR, 32'h1000 + 32'(k), 32'h2008 - 32'(k)); end
            held_src = bus.O_SRC_ADDR;
            held_dst = bus.O_DST_ADDR;
            bus.I_READY = 1'b0;
            if (k == 4) bus.I_START = 1'b1;
            tick();
            bus.I_START = 1'b0;
            n_cmp++; if (bus.O_VALID !== 1'b1 || bus.O_SRC_ADDR !== held_src || bus.O_DST_ADDR !== held_dst) begin n_bad++; $display("FAIL dir180_stall[%0d]: got v=%b %h/%h want v=1 %h/%h", k, bus.O_VALID, bus.O_SRC_ADDR, bus.O_DST_ADDR, held_src, held_dst); end
            bus.I_READY = 1'b1;
            tick();
        end
        n_cmp++; if (bus.O_VALID !== 1'b0 || bus.O_DONE !== 1'b1) begin n_bad++; $display("FAIL dir180_done: v/d got %b%b want 01", bus.O_VALID, bus.O_DONE); end
        tick();
    endtask

    task automatic test_empty();
        bus.I_READY = 1'b1;
        start_job(10'd0, 10'd5, 2'd0, 32'h10, 32'h20);
        n_cmp++; if ({bus.O_VALID, bus.O_BUSY, bus.O_DONE} !== 3'b001) begin n_bad++; $display("FAIL empty_w: v/b/d got %b want 001", {bus.O_VALID, bus.O_BUSY, bus.O_DONE}); end
        tick();
        n_cmp++; if (bus.O_VALID !== 1'b0 || bus.O_DONE !== 1'b0) begin n_bad++; $display("FAIL empty_w_after: v/d got %b%b want 00", bus.O_VALID, bus.O_DONE); end
        start_job(10'd3, 10'd0, 2'd1, 32'h10, 32'h20);
        n_cmp++; if ({bus.O_VALID, bus.O_DONE} !== 2'b01) begin n_bad++; $display("FAIL empty_h: v/d got %b want 01", {bus.O_VALID, bus.O_DONE}); end
        tick();
    endtask

    task automatic test_abort();
        bus.I_READY = 1'b1;
        start_job(10'd4, 10'd2, 2'd0, 32'h10, 32'h20);
        tick(); tick(); tick();
        n_cmp++; if (bus.O_SRC_ADDR !== 32'h13) begin n_bad++; $display("FAIL abort_pre: src got %h want 13", bus.O_SRC_ADDR); end
        bus.I_ABORT = 1'b1;
        tick();
        bus.I_ABORT = 1'b0;
        n_cmp++; if ({bus.O_VALID, bus.O_BUSY, bus.O_DONE} !== 3'b000) begin n_bad++; $display("FAIL abort_stop: v/b/d got %b want 000", {bus.O_VALID, bus.O_BUSY, bus.O_DONE}); end
        tick();
        n_cmp++; if (bus.O_DONE !== 1'b0 || bus.O_VALID !== 1'b0) begin n_bad++; $display("FAIL abort_nodone: v/d got %b%b want 00", bus.O_VALID, bus.O_DONE); end
        // Abort together with start in IDLE keeps the block idle.
        bus.I_ABORT = 1'b1;
        start_job(10'd4, 10'd2, 2'd0, 32'h10, 32'h20);
        bus.I_ABORT = 1'b0;
        n_cmp++; if (bus.O_VALID !== 1'b0 || bus.O_BUSY !== 1'b0) begin n_bad++; $display("FAIL abort_start: v/b got %b%b want 00", bus.O_VALID, bus.O_BUSY); end
        start_job(10'd4, 10'd2, 2'd0, 32'h10, 32'h20);
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (bus.O_VALID !== 1'b1 || bus.O_SRC_ADDR !== 32'h10 + 32'(k) || bus.O_DST_ADDR !== 32'h20 + 32'(k)) begin n_bad++; $display("FAIL restart[%0d]: got v=%b %h/%h want v=1 %h/%h", k, bus.O_VALID, bus.O_SRC_ADDR, bus.O_DST_ADDR, 32'h10 + 32'(k), 32'h20 + 32'(k)); end
            tick();
        end
        n_cmp++; if (bus.O_DONE !== 1'b1) begin n_bad++; $display("FAIL restart_done: got %b want 1", bus.O_DONE); end
        tick();
    endtask

    task automatic test_wrap_and_reset();
        bus.I_READY = 1'b0;
        start_job(10'd2, 10'd1, 2'd0, 32'hFFFFFFFF, 32'h40);
        n_cmp++; if (bus.O_SRC_ADDR !== 32'hFFFFFFFF || bus.O_DST_ADDR !== 32'h40) begin n_bad++; $display("FAIL wrap_first: got %h/%h want ffffffff/40", bus.O_SRC_ADDR, bus.O_DST_ADDR); end
        bus.I_START = 1'b1;
        tick();
        bus.I_START = 1'b0;
        n_cmp++; if (bus.O_VALID !== 1'b1 || bus.O_SRC_ADDR !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL start_in_run: got v=%b %h want v=1 ffffffff", bus.O_VALID, bus.O_SRC_ADDR); end
        bus.I_READY = 1'b1;
        tick();
        n_cmp++; if (bus.O_SRC_ADDR !== 32'h0 || bus.O_DST_ADDR !== 32'h41) begin n_bad++; $display("FAIL wrap_second: got %h/%h want 0/41", bus.O_SRC_ADDR, bus.O_DST_ADDR); end
        tick();
        n_cmp++; if (bus.O_DONE !== 1'b1) begin n_bad++; $display("FAIL wrap_done: got %b want 1", bus.O_DONE); end
        tick();
        // Asynchronous reset in the middle of a job.
        start_job(10'd4, 10'd4, 2'd1, 32'h300, 32'h400);
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.O_VALID, bus.O_BUSY, bus.O_DONE} !== 3'b000 || {bus.O_SRC_ADDR, bus.O_DST_ADDR} !== 64'h0) begin n_bad++; $display("FAIL async_reset: v/b/d %b addr %h/%h want 000 0/0", {bus.O_VALID, bus.O_BUSY, bus.O_DONE}, bus.O_SRC_ADDR, bus.O_DST_ADDR); end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (bus.O_VALID !== 1'b0 || bus.O_DONE !== 1'b0) begin n_bad++; $display("FAIL post_reset[%0d]: v/d got %b%b want 00", k, bus.O_VALID, bus.O_DONE); end
        end
    endtask

`ifdef ROTATE_ADDR_GEN_PERF_EN
    task automatic test_perf();
        bus.I_READY = 1'b0;
        start_job(10'd2, 10'd2, 2'd0, 32'h0, 32'h0);
        n_cmp++; if (bus.O_CYCLES !== 32'd0) begin n_bad++; $display("FAIL perf_clear: got %0d want 0", bus.O_CYCLES); end
        tick(); tick(); tick();
        bus.I_READY = 1'b1;
        tick(); tick(); tick(); tick();
        n_cmp++; if (bus.O_DONE !== 1'b1 || bus.O_CYCLES !== 32'd7) begin n_bad++; $display("FAIL perf_count: done %b cycles %0d want 1/7", bus.O_DONE, bus.O_CYCLES); end
        tick(); tick();
        n_cmp++; if (bus.O_CYCLES !== 32'd7) begin n_bad++; $display("FAIL perf_hold: got %0d want 7", bus.O_CYCLES); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        bus.I_START = 1'b0; bus.I_ABORT = 1'b0; bus.I_READY = 1'b0;
        bus.I_WIDTH = '0; bus.I_HEIGHT = '0; bus.I_DIR = '0;
        bus.I_SRC_BASE = '0; bus.I_DST_BASE = '0;
        test_reset();
        test_dir90();
        test_dir270();
        test_stall_dir180();
        test_empty();
        test_abort();
        test_wrap_and_reset();
`ifdef ROTATE_ADDR_GEN_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
